// File: rtl/hex_operand_loader.sv
// Purpose: assembles a serial hex-digit stream into a double-buffered operand pair (A, B) for the magnitude comparator.
// Latency: a/b/op_valid/frame_cnt update on the edge that accepts the 2*NDIG-th digit; sync_err pulses the cycle after an offending digit.
// Backpressure: nib_ready drops only while a completed pair waits for op_ack (and during reset); it never depends on nib_valid.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   nib_in, nib_sof           hex digit and start-of-frame marker (first digit of A)
//   nib_valid, nib_ready      digit handshake; a transfer is nib_valid && nib_ready at a rising edge
//   a, b                      operands, element [NDIG-1] is the most-significant digit
//   op_valid, op_ack          completed pair is held until the consumer acknowledges it
//   sync_err                  one-cycle pulse on a missing or unexpected start-of-frame
//   frame_cnt                 completed frames, wraps 255 -> 0
module hex_operand_loader #(
  parameter int NDIG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           nib_in,
  input  logic                 nib_sof,
  input  logic                 nib_valid,
  output logic                 nib_ready,
  output logic [NDIG-1:0][3:0] a,
  output logic [NDIG-1:0][3:0] b,
  output logic                 op_valid,
  input  logic                 op_ack,
  output logic                 sync_err,
  output logic [7:0]           frame_cnt
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    WAIT_SOF,
    LOAD_A,
    LOAD_B,
    HOLD
  } state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx, idx_nxt;       // digit index within the operand being loaded
  logic [NDIG-1:0][3:0] sh_a, sh_b;         // shadow operands, invisible to the comparator
  logic [NDIG-1:0][3:0] sh_a_nxt, sh_b_nxt;
  logic                 err_nxt;
  logic                 load_pair;
  logic                 clr_valid;
  logic                 fire;
  logic                 last_dig;

  // Ready is a pure function of state and rst so the upstream can never see a loop through nib_valid.
  assign nib_ready = !rst && (state != HOLD);
  assign fire      = nib_valid && nib_ready;
  assign last_dig  = (idx == IW'(NDIG - 1));

  // Digit index 0 is the most-significant digit, stored in element [NDIG-1].
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] i);
    return IW'(NDIG - 1) - i;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    err_nxt   = 1'b0;
    load_pair = 1'b0;
    clr_valid = 1'b0;

    case (state)
      WAIT_SOF: begin
        if (fire) begin
          if (nib_sof) begin
            sh_a_nxt[NDIG-1] = nib_in;
            idx_nxt          = IW'(1);
            state_nxt        = LOAD_A;
          end else begin
            // Stray digit outside a frame: drop it and keep hunting for a start marker.
            err_nxt = 1'b1;
          end
        end
      end

      LOAD_A, LOAD_B: begin
        if (fire) begin
          if (nib_sof) begin
            // A new start marker mid-frame abandons the partial frame and
            // restarts collection with this digit as A's leading digit.
            err_nxt          = 1'b1;
            sh_a_nxt[NDIG-1] = nib_in;
            idx_nxt          = IW'(1);
            state_nxt        = LOAD_A;
          end else if (state == LOAD_A) begin
            sh_a_nxt[slot(idx)] = nib_in;
            if (last_dig) begin
              idx_nxt   = '0;
              state_nxt = LOAD_B;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            sh_b_nxt[slot(idx)] = nib_in;
            if (last_dig) begin
              idx_nxt   = '0;
              state_nxt = HOLD;
              load_pair = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
      end

      HOLD: begin
        if (op_ack) begin
          state_nxt = WAIT_SOF;
          clr_valid = 1'b1;
        end
      end

      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_SOF;
      idx       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      a         <= '0;
      b         <= '0;
      op_valid  <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      sh_a     <= sh_a_nxt;
      sh_b     <= sh_b_nxt;
      sync_err <= err_nxt;
      // The output pair is copied from the next-shadow value so the final
      // B digit lands in b on the same edge that accepts it.
      if (load_pair) begin
        a         <= sh_a_nxt;
        b         <= sh_b_nxt;
        op_valid  <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (clr_valid) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule
